// File: rtl/step_pulse_sequencer.sv
// Step pulse sequencer: drives a triggered timer once per step and emits a fixed-width
// step pulse after each timer expiry, until the commanded step count is exhausted.
module step_pulse_sequencer #(
    parameter int STEPS_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int PULSE_TICKS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    cmd_valid,
    input  logic [STEPS_WIDTH-1:0]  cmd_steps,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    output logic                    cmd_rdy,
    input  logic                    abort,
    output logic                    timer_trigger,
    output logic [PERIOD_WIDTH-1:0] timer_period,
    input  logic                    timer_rdy,
    input  logic                    timer_done,
    output logic                    step,
    output logic [STEPS_WIDTH-1:0]  steps_left,
    output logic                    busy,
    output logic                    done
);

    localparam int PCW = $clog2(PULSE_TICKS + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TRIG   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_PULSE  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [STEPS_WIDTH-1:0] ONE_STEP   = STEPS_WIDTH'(1);
    localparam logic [PCW-1:0]         PULSE_LOAD = PCW'(PULSE_TICKS);
    localparam logic [PCW-1:0]         PULSE_ONE  = PCW'(1);

    logic [2:0]     state;
    logic [PCW-1:0] pulse_cnt;
    logic           abortable;

    // Saturating decrement so the step count can never wrap below zero.
    function automatic logic [STEPS_WIDTH-1:0] sat_dec(input logic [STEPS_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - ONE_STEP;
    endfunction

    assign abortable = (state == ST_TRIG) || (state == ST_WAIT) || (state == ST_PULSE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            steps_left   <= '0;
            timer_period <= '0;
            pulse_cnt    <= '0;
        end else if (clk_en) begin
            if (abort && abortable) begin
                state      <= ST_FINISH;
                steps_left <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            steps_left   <= cmd_steps;
                            timer_period <= cmd_period;
                            state        <= (cmd_steps == '0) ? ST_FINISH : ST_TRIG;
                        end
                    end
                    ST_TRIG: begin
                        if (timer_rdy) state <= ST_WAIT;
                    end
                    // timer_done is also high while the timer idles; only the done phase counts
                    ST_WAIT: begin
                        if (timer_done && !timer_rdy) begin
                            state     <= ST_PULSE;
                            pulse_cnt <= PULSE_LOAD;
                        end
                    end
                    ST_PULSE: begin
                        if (pulse_cnt == PULSE_ONE) begin
                            steps_left <= sat_dec(steps_left);
                            state      <= (steps_left == ONE_STEP) ? ST_FINISH : ST_TRIG;
                        end else begin
                            pulse_cnt <= pulse_cnt - PULSE_ONE;
                        end
                    end
                    ST_FINISH: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_rdy       = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign step          = (state == ST_PULSE);
    assign done          = (state == ST_FINISH);
    assign timer_trigger = (state == ST_TRIG) && timer_rdy;

endmodule
